// File: rtl/tcm_inst_write_slave_if.sv
// Bus bundle for the instruction-TCM write responder: writer side, TCM port side and status.
interface tcm_inst_write_slave_if #(
   parameter int unsigned ADDR_W = 16
) ();
   logic [3:0]        tb_inst_we_i;
   logic [31:0]       tb_inst_addr_i;
   logic [31:0]       tb_inst_data_i;
   logic              clr_i;
   logic              tcm_req_o;
   logic              tcm_gnt_i;
   logic [3:0]        tcm_we_o;
   logic [ADDR_W-3:0] tcm_addr_o;
   logic [31:0]       tcm_wdata_o;
   logic [31:0]       wr_count_o;
   logic              err_align_o;
   logic              err_range_o;
   logic              overflow_o;
   logic              idle_o;
   logic [31:0]       checksum_o;

   modport slave (
      input  tb_inst_we_i, tb_inst_addr_i, tb_inst_data_i, clr_i, tcm_gnt_i,
      output tcm_req_o, tcm_we_o, tcm_addr_o, tcm_wdata_o, wr_count_o,
             err_align_o, err_range_o, overflow_o, idle_o, checksum_o
   );

   modport master (
      output tb_inst_we_i, tb_inst_addr_i, tb_inst_data_i, clr_i, tcm_gnt_i,
      input  tcm_req_o, tcm_we_o, tcm_addr_o, tcm_wdata_o, wr_count_o,
             err_align_o, err_range_o, overflow_o, idle_o, checksum_o
   );
endinterface

// File: rtl/tcm_inst_write_slave.sv
// Instruction-TCM preload responder: validates word writes, buffers them, drains under grant.
// Optional feature macro INST_WR_CHECKSUM_EN adds a running checksum of committed (masked) data.
module tcm_inst_write_slave #(
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input logic                   clk_i,
   input logic                   rst_x,
   tcm_inst_write_slave_if.slave bus
);
   localparam int unsigned WA_W  = ADDR_W - 2;
   localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef struct packed {
      logic [3:0]      we;
      logic [WA_W-1:0] waddr;
      logic [31:0]     data;
   } entry_t;

   typedef enum logic {ST_EMPTY = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t           r_state, w_state_nxt;
   entry_t           r_mem [FIFO_DEPTH];
   entry_t           r_head, w_in, w_head_nxt;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt, w_occ;
   logic [31:0]      r_count;
   logic             r_err_align, r_err_range, r_ovf;
   logic             w_req, w_wr, w_aligned, w_in_range, w_full, w_pop, w_push;
   logic             w_drop_align, w_drop_range, w_drop_ovf;

   // Write classification; the first failing check owns the drop.
   assign w_req        = (r_state == ST_DRAIN);
   assign w_wr         = |bus.tb_inst_we_i;
   assign w_aligned    = (bus.tb_inst_addr_i[1:0] == 2'b00);
   assign w_in_range   = ((bus.tb_inst_addr_i >> ADDR_W) == 32'd0);
   assign w_occ        = r_wr_ptr - r_rd_ptr;
   assign w_full       = ((r_wr_ptr ^ r_rd_ptr) == PTR_W'(FIFO_DEPTH));
   assign w_pop        = w_req & bus.tcm_gnt_i;
   assign w_push       = w_wr & w_aligned & w_in_range & (~w_full | w_pop);
   assign w_drop_align = w_wr & ~w_aligned;
   assign w_drop_range = w_wr & w_aligned & ~w_in_range;
   assign w_drop_ovf   = w_wr & w_aligned & w_in_range & w_full & ~w_pop;

   assign w_rd_nxt = r_rd_ptr + PTR_W'(w_pop);
   assign w_in     = {bus.tb_inst_we_i, bus.tb_inst_addr_i[ADDR_W-1:2], bus.tb_inst_data_i};
   // Incoming word becomes head only when the FIFO would otherwise be empty after this pop.
   assign w_head_nxt = (w_push && (r_wr_ptr == w_rd_nxt)) ? w_in : r_mem[w_rd_nxt[IDX_W-1:0]];

   always_ff @(posedge clk_i or negedge rst_x) begin
      if (!rst_x) r_state <= ST_EMPTY;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: if (w_push) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_pop && !w_push && (w_occ == PTR_W'(1))) w_state_nxt = ST_EMPTY;
         default:  w_state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= w_in;
   end

   // Pointers and the registered head presented to the TCM port.
   always_ff @(posedge clk_i or negedge rst_x) begin
      if (!rst_x) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_head   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         r_rd_ptr <= w_rd_nxt;
         if ((w_push || w_pop) && (w_state_nxt == ST_DRAIN)) r_head <= w_head_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_x) begin
      if (!rst_x) begin
         r_count     <= '0;
         r_err_align <= 1'b0;
         r_err_range <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (bus.clr_i) begin
         r_count     <= '0;
         r_err_align <= 1'b0;
         r_err_range <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         if (w_pop) r_count <= r_count + 32'd1;
         r_err_align <= r_err_align | w_drop_align;
         r_err_range <= r_err_range | w_drop_range;
         r_ovf       <= r_ovf | w_drop_ovf;
      end
   end

`ifdef INST_WR_CHECKSUM_EN
   logic [31:0] r_cksum;
   logic [31:0] w_mask;

   assign w_mask = {{8{r_head.we[3]}}, {8{r_head.we[2]}}, {8{r_head.we[1]}}, {8{r_head.we[0]}}};

   always_ff @(posedge clk_i or negedge rst_x) begin
      if (!rst_x)          r_cksum <= '0;
      else if (bus.clr_i)  r_cksum <= '0;
      else if (w_pop)      r_cksum <= r_cksum + (r_head.data & w_mask);
   end

   assign bus.checksum_o = r_cksum;
`else
   assign bus.checksum_o = 32'd0;
`endif

   assign bus.tcm_req_o   = w_req;
   assign bus.idle_o      = ~w_req;
   assign bus.tcm_we_o    = r_head.we;
   assign bus.tcm_addr_o  = r_head.waddr;
   assign bus.tcm_wdata_o = r_head.data;
   assign bus.wr_count_o  = r_count;
   assign bus.err_align_o = r_err_align;
   assign bus.err_range_o = r_err_range;
   assign bus.overflow_o  = r_ovf;
endmodule

// File: tb/tb_tcm_inst_write_slave.sv
// Self-checking bench for tcm_inst_write_slave: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_tcm_inst_write_slave;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned WA_W   = ADDR_W - 2;

   logic clk_i = 1'b0;
   logic rst_x = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clk_i = ~clk_i;

   tcm_inst_write_slave_if #(.ADDR_W(ADDR_W)) bus ();

   tcm_inst_write_slave #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk_i (clk_i),
      .rst_x (rst_x),
      .bus   (bus)
   );

   // Reference model: a queue of accepted writes plus commit statistics.
   typedef struct {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] data;
   } ment_t;

   ment_t       mq[$];
   logic [31:0] m_count;
   bit          m_align, m_range, m_ovf;
   logic [31:0] m_ck;

   typedef struct {
      logic [3:0]      we;
      logic [31:0]     addr;
      logic [31:0]     data;
      bit              gnt;
      bit              clr;
      bit              e_req;
      logic [WA_W-1:0] e_wa;
      logic [31:0]     e_wd;
      logic [31:0]     e_cnt;
      logic [2:0]      e_flg;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] be_mask(input logic [3:0] we, input logic [31:0] d);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[b*8 +: 8] = we[b] ? 8'hFF : 8'h00;
      return d & m;
   endfunction

   function automatic logic [31:0] ck_exp(input logic [31:0] v);
`ifdef INST_WR_CHECKSUM_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   task automatic model_reset();
      mq.delete();
      m_count = '0;
      m_align = 0;
      m_range = 0;
      m_ovf   = 0;
      m_ck    = '0;
   endtask

   task automatic model_step(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                             input bit gnt, input bit clr);
      bit    pop, acc, ea, er, eo;
      ment_t h;
      ment_t n;
      pop = (mq.size() > 0) && gnt;
      acc = 0; ea = 0; er = 0; eo = 0;
      if (we != 4'h0) begin
         if (addr % 4 != 0)                         ea = 1;
         else if (addr >= (32'd1 << ADDR_W))        er = 1;
         else if (mq.size() == DEPTH && !pop)       eo = 1;
         else                                       acc = 1;
      end
      if (pop) begin
         h = mq.pop_front();
         m_count = m_count + 32'd1;
         m_ck    = m_ck + be_mask(h.we, h.data);
      end
      if (acc) begin
         n.we = we; n.addr = addr; n.data = data;
         mq.push_back(n);
      end
      if (clr) begin
         m_count = '0; m_align = 0; m_range = 0; m_ovf = 0; m_ck = '0;
      end else begin
         m_align |= ea; m_range |= er; m_ovf |= eo;
      end
   endtask

   task automatic compare_model();
      chk("m_req",   32'(bus.tcm_req_o),   32'(mq.size() > 0));
      chk("m_idle",  32'(bus.idle_o),      32'(mq.size() == 0));
      chk("m_count", bus.wr_count_o,       m_count);
      chk("m_align", 32'(bus.err_align_o), 32'(m_align));
      chk("m_range", 32'(bus.err_range_o), 32'(m_range));
      chk("m_ovf",   32'(bus.overflow_o),  32'(m_ovf));
      chk("m_cksum", bus.checksum_o,       ck_exp(m_ck));
      if (mq.size() > 0) begin
         chk("m_head_we",   32'(bus.tcm_we_o),   32'(mq[0].we));
         chk("m_head_addr", 32'(bus.tcm_addr_o), mq[0].addr >> 2);
         chk("m_head_data", bus.tcm_wdata_o,     mq[0].data);
      end
   endtask

   task automatic cycle(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                        input bit gnt, input bit clr);
      bus.tb_inst_we_i   = we;
      bus.tb_inst_addr_i = addr;
      bus.tb_inst_data_i = data;
      bus.tcm_gnt_i      = gnt;
      bus.clr_i          = clr;
      model_step(we, addr, data, gnt, clr);
      @(posedge clk_i);
      #1;
      compare_model();
   endtask

   task automatic add(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] data,
                      input bit gnt, input bit clr, input bit e_req, input logic [WA_W-1:0] e_wa,
                      input logic [31:0] e_wd, input logic [31:0] e_cnt, input logic [2:0] e_flg);
      vec_t v;
      v.we = we; v.addr = addr; v.data = data; v.gnt = gnt; v.clr = clr;
      v.e_req = e_req; v.e_wa = e_wa; v.e_wd = e_wd; v.e_cnt = e_cnt; v.e_flg = e_flg;
      tbl.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      int          sel;
      bit          gnt_r;

      bus.tb_inst_we_i = '0; bus.tb_inst_addr_i = '0; bus.tb_inst_data_i = '0;
      bus.tcm_gnt_i = 1'b0; bus.clr_i = 1'b0;
      model_reset();

      #12;
      chk("rst_req",   32'(bus.tcm_req_o),   32'd0);
      chk("rst_idle",  32'(bus.idle_o),      32'd1);
      chk("rst_count", bus.wr_count_o,       32'd0);
      chk("rst_flags", 32'({bus.err_align_o, bus.err_range_o, bus.overflow_o}), 32'd0);
      chk("rst_cksum", bus.checksum_o,       32'd0);
      chk("rst_head",  32'({bus.tcm_we_o, bus.tcm_addr_o}) | bus.tcm_wdata_o, 32'd0);
      @(negedge clk_i);
      rst_x = 1'b1;

      // we, addr, data, gnt, clr | req, word addr, data, count, {align,range,ovf}
      add(4'hF, 32'h0,     32'h00000013, 1, 0,  1, 14'h0,    32'h00000013, 0, 3'b000);
      add(4'hF, 32'h4,     32'h00100093, 1, 0,  1, 14'h1,    32'h00100093, 1, 3'b000);
      add(4'hF, 32'h8,     32'h00200113, 1, 0,  1, 14'h2,    32'h00200113, 2, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  0, 14'h0,    32'h0,        3, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  0, 14'h0,    32'h0,        3, 3'b000);
      add(4'h0, 32'h0,     32'h0,        0, 1,  0, 14'h0,    32'h0,        0, 3'b000);
      add(4'hF, 32'h10,    32'hA0,       0, 0,  1, 14'h4,    32'hA0,       0, 3'b000);
      add(4'hF, 32'h14,    32'hA1,       0, 0,  1, 14'h4,    32'hA0,       0, 3'b000);
      add(4'hF, 32'h18,    32'hA2,       0, 0,  1, 14'h4,    32'hA0,       0, 3'b000);
      add(4'hF, 32'h1C,    32'hA3,       0, 0,  1, 14'h4,    32'hA0,       0, 3'b000);
      add(4'hF, 32'h20,    32'hA4,       0, 0,  1, 14'h4,    32'hA0,       0, 3'b001);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h5,    32'hA1,       1, 3'b001);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h6,    32'hA2,       2, 3'b001);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h7,    32'hA3,       3, 3'b001);
      add(4'h0, 32'h0,     32'h0,        1, 0,  0, 14'h0,    32'h0,        4, 3'b001);
      add(4'h0, 32'h0,     32'h0,        0, 1,  0, 14'h0,    32'h0,        0, 3'b000);
      add(4'hF, 32'h2,     32'h11,       0, 0,  0, 14'h0,    32'h0,        0, 3'b100);
      add(4'hF, 32'h10000, 32'h22,       0, 1,  0, 14'h0,    32'h0,        0, 3'b000);
      add(4'hF, 32'h10000, 32'h22,       0, 0,  0, 14'h0,    32'h0,        0, 3'b010);
      add(4'h0, 32'h0,     32'h0,        0, 1,  0, 14'h0,    32'h0,        0, 3'b000);
      add(4'hF, 32'h10002, 32'h33,       0, 0,  0, 14'h0,    32'h0,        0, 3'b100);
      add(4'hF, 32'hFFFC,  32'h55,       0, 0,  1, 14'h3FFF, 32'h55,       0, 3'b100);
      add(4'h0, 32'h0,     32'h0,        1, 1,  0, 14'h0,    32'h0,        0, 3'b000);
      add(4'hF, 32'h100,   32'hB0,       0, 0,  1, 14'h40,   32'hB0,       0, 3'b000);
      add(4'hF, 32'h104,   32'hB1,       0, 0,  1, 14'h40,   32'hB0,       0, 3'b000);
      add(4'hF, 32'h108,   32'hB2,       0, 0,  1, 14'h40,   32'hB0,       0, 3'b000);
      add(4'hF, 32'h10C,   32'hB3,       0, 0,  1, 14'h40,   32'hB0,       0, 3'b000);
      add(4'hF, 32'h110,   32'hB4,       1, 0,  1, 14'h41,   32'hB1,       1, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h42,   32'hB2,       2, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h43,   32'hB3,       3, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  1, 14'h44,   32'hB4,       4, 3'b000);
      add(4'h0, 32'h0,     32'h0,        1, 0,  0, 14'h0,    32'h0,        5, 3'b000);

      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].gnt, tbl[i].clr);
         chk($sformatf("v%0d_req", i),   32'(bus.tcm_req_o), 32'(tbl[i].e_req));
         chk($sformatf("v%0d_idle", i),  32'(bus.idle_o),    32'(!tbl[i].e_req));
         chk($sformatf("v%0d_count", i), bus.wr_count_o,     tbl[i].e_cnt);
         chk($sformatf("v%0d_flags", i),
             32'({bus.err_align_o, bus.err_range_o, bus.overflow_o}), 32'(tbl[i].e_flg));
         if (tbl[i].e_req) begin
            chk($sformatf("v%0d_waddr", i), 32'(bus.tcm_addr_o), 32'(tbl[i].e_wa));
            chk($sformatf("v%0d_wdata", i), bus.tcm_wdata_o,     tbl[i].e_wd);
         end
      end

      // Checksum with full and partial byte enables.
      cycle(4'h0, 32'h0, 32'h0, 0, 1);
      cycle(4'hF, 32'h0, 32'h00000013, 1, 0);
      cycle(4'hF, 32'h4, 32'h00100093, 1, 0);
      chk("cksum_two", bus.checksum_o, ck_exp(32'h00000013));
      cycle(4'h1, 32'h8, 32'hFFFFFFFF, 1, 0);
      chk("cksum_two_b", bus.checksum_o, ck_exp(32'h001000A6));
      cycle(4'h0, 32'h0, 32'h0, 1, 0);
      chk("cksum_three", bus.checksum_o, ck_exp(32'h001001A5));
      chk("cksum_count", bus.wr_count_o, 32'd3);

      // Asynchronous reset while two entries wait for grant.
      cycle(4'hF, 32'h200, 32'hC0, 0, 0);
      cycle(4'hF, 32'h204, 32'hC1, 0, 0);
      #2;
      rst_x = 1'b0;
      #1;
      chk("midrst_req",   32'(bus.tcm_req_o), 32'd0);
      chk("midrst_idle",  32'(bus.idle_o),    32'd1);
      chk("midrst_count", bus.wr_count_o,     32'd0);
      model_reset();
      bus.tb_inst_we_i = '0;
      bus.tcm_gnt_i    = 1'b1;
      @(negedge clk_i);
      rst_x = 1'b1;
      cycle(4'h0, 32'h0, 32'h0, 1, 0);
      chk("postrst_count", bus.wr_count_o, 32'd0);

      // Randomized traffic; grant is sparse early to exercise full and overflow.
      for (int n = 0; n < 600; n++) begin
         sel = int'($urandom_range(0, 19));
         if (sel == 0)      ra = 32'($urandom_range(0, 16'hFFFF)) | 32'd1;
         else if (sel == 1) ra = 32'h10000 + (32'($urandom_range(0, 4095)) << 2);
         else               ra = 32'($urandom_range(0, 16'h3FFF)) << 2;
         gnt_r = (n < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15)), ra, $urandom,
               gnt_r, $urandom_range(0, 49) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tcm_inst_write_slave.md
# tcm_inst_write_slave

Responder side of the instruction-TCM write port (`tb_inst_we_i` / `tb_inst_addr_i` / `tb_inst_data_i`) used to preload program images before the core is released from reset. It accepts one word write per cycle, checks alignment and range, and buffers each accepted write in a small FIFO. It drains the FIFO into the TCM write port under an external arbiter grant shared with instruction fetch. It also reports a committed-word count and sticky error flags, so a loader can confirm that the whole image landed.

## Interface
- `ADDR_W`, 16: byte-address width of the TCM. Valid addresses are below 2^ADDR_W.
- `FIFO_DEPTH`, 4: buffered writes. Must be a power of 2, ≥ 2.
- `clk_i`  in  1  clock. One clock domain.
- `rst_x`  in  1  asynchronous, active-low reset.
- `tb_inst_we_i`  in  4  byte enables. A write is present when the value is non-zero.
- `tb_inst_addr_i`  in  32  byte address.
- `tb_inst_data_i`  in  32  write data.
- `clr_i`  in  1  synchronous clear of the count, error flags and checksum. Does not flush the FIFO.
- `tcm_req_o`  out  1  FIFO head valid; requests the TCM write port.
- `tcm_gnt_i`  in  1  arbiter grant. Fetch has priority.
- `tcm_we_o`  out  4  head byte enables.
- `tcm_addr_o`  out  ADDR_W-2  head word address.
- `tcm_wdata_o`  out  32  head data.
- `wr_count_o`  out  32  number of committed words.
- `err_align_o`  out  1  sticky flag: misaligned write dropped.
- `err_range_o`  out  1  sticky flag: out-of-range write dropped.
- `overflow_o`  out  1  sticky flag: write dropped because the FIFO was full.
- `idle_o`  out  1  FIFO empty.
- `checksum_o`  out  32  see Configuration.

## Operation
- **Accept rule.** A write is accepted when all of the following hold:
  - `we != 0`;
  - `addr[1:0] == 0`;
  - `addr[31:ADDR_W] == 0`;
  - the FIFO is not full, or a pop occurs in the same cycle.
- **Drop rules.** Checks are applied in priority order; a write sets exactly one flag, the first that fails:
  - misaligned: sets `err_align_o`;
  - out of range: sets `err_range_o`;
  - FIFO full with no pop: sets `overflow_o`.
- **Writer interface.** There is no backpressure toward the writer. The writer must pace itself using `idle_o` or the FIFO depth.
- **FIFO.** Each entry holds {we, word address, data}.
  - Read and write pointers are ADDR-independent, $clog2(FIFO_DEPTH)+1 bits wide, and wrap modulo 2×depth.
  - Full when the pointers differ only in the MSB. Empty when they are equal.
- **Pop and commit.** A pop happens on `tcm_req_o && tcm_gnt_i`. On a pop, `wr_count_o` increments. It wraps at 2^32 with no flag.
- **Head registers.** `tcm_we_o`, `tcm_addr_o` and `tcm_wdata_o` are registered from the FIFO head. They hold steady while `tcm_req_o` is high and grant is low.
- **Clear.** `clr_i` zeroes the count, the flags and the checksum. If a commit or drop coincides with `clr_i`, the clear wins.
- **States.** Two states, derived from the FIFO occupancy:
  - EMPTY (`idle_o`=1, `tcm_req_o`=0);
  - DRAIN (`tcm_req_o`=1).
  - EMPTY→DRAIN on the first accept. DRAIN→EMPTY on the pop of the last entry with no simultaneous accept.

## Timing
- **Reset.** All outputs are 0, except `idle_o`=1. The FIFO is flushed.
- **Reset mid-drain.** An un-committed entry is lost, and `tcm_req_o` falls asynchronously.
- **Latency.** A write accepted at edge N drives `tcm_req_o` from N+1. With grant high, it commits at edge N+1, and `wr_count_o` reflects it after N+1.
- **Throughput.** One commit per cycle with continuous grant. Writes every cycle with grant always high never overflow.
- **Full FIFO.** A push and a pop in the same cycle on a full FIFO are both honoured; occupancy is unchanged.
- **Empty FIFO.** An accept into an empty FIFO does not bypass to the head. The one-cycle latency applies.
- **Grant without request.** `tcm_gnt_i` while `tcm_req_o`=0 is ignored.

## Configuration
- `INST_WR_CHECKSUM_EN` defined: on each commit, `checksum_o` += (data masked per byte enable), modulo 2^32. It is registered and updates at the commit edge.
- `INST_WR_CHECKSUM_EN` not defined: `checksum_o` is tied to 0 and no adder is built.

## Test plan
1. **Back-to-back writes, grant held high.** Write 0x00000013@0x0, 0x00100093@0x4, 0x00200113@0x8 on consecutive cycles.
   - Each appears on `tcm_*` one cycle after its write.
   - `wr_count_o`=3; `idle_o`=1 two cycles after the last write.
2. **Overflow with grant held low.** Write 5 words (FIFO_DEPTH=4).
   - The 5th is dropped and `overflow_o`=1.
   - After raising grant: 4 commits, `wr_count_o`=4.
3. **Alignment and range errors.**
   - Write to 0x2: `err_align_o`=1, no commit.
   - Write to 0x10000 (ADDR_W=16): `err_range_o`=1.
   - Write to 0x10002: only `err_align_o` is set.
4. **Checksum (macro on).** Commit 0x00000013 then 0x00100093 with we=0xF: `checksum_o`=0x001000A6. Then commit 0xFFFFFFFF with we=0x1: `checksum_o`=0x001001A5.
5. **Reset mid-drain and clear.**
   - Two writes pending with grant low, then assert `rst_x` low: `tcm_req_o`=0, `idle_o`=1, count 0.
   - Separately, `clr_i` coinciding with a commit leaves `wr_count_o`=0.
6. **Simultaneous push and pop.** Fill the FIFO to full, then apply grant and a new write in the same cycle: no overflow, occupancy stays 4.
